// File: rtl/sa_signal_word_packer.sv
// -----------------------------------------------------------------------------
// sa_signal_word_packer
//
// Collects one control-field beat per systolic-array row and packs
// N_ROWS_ARRAY beats into one signal word. Each word is written to the
// control-signal memory at base + word index. The array controller unpacks
// these words, so the bit layout below must match its decoder exactly.
//
// Packed word layout (row j, low bits first):
//   f_sel      : [j*SEL_WIDTH +: SEL_WIDTH]
//   num_cols   : [R*SEL_WIDTH + j*NUM_COL_WIDTH +: NUM_COL_WIDTH]
//   sel_mux_tr : [R*(SEL_WIDTH+NUM_COL_WIDTH) + j*SEL_MUX_TR_WIDTH +: ...]
//   en_adder   : bit R*(SEL_WIDTH+NUM_COL_WIDTH+SEL_MUX_TR_WIDTH) + j
//   where R = N_ROWS_ARRAY. All bits above the fields are zero.
//
// Ports:
//   clk_i            clock, all state on the rising edge
//   f_sel_rst        asynchronous active-high reset
//   start_i          session start pulse, honoured only in IDLE
//   base_addrs_i     first write address, captured on start
//   num_words_i      words in the session, captured on start (0 = none)
//   row_valid_i      row beat valid
//   row_ready_o      packer accepts a beat (high throughout COLLECT)
//   row_f_sel_i      filter-select field
//   row_num_cols_i   column-count field
//   row_sel_mux_tr_i transfer-mux select field
//   row_en_adder_i   adder-node enable field
//   wr_en_o          one-cycle memory write strobe
//   wr_addrs_o       write address (holds after the write)
//   wr_data_o        packed word (holds after the write)
//   busy_o           session in progress
//   done_o           one-cycle end-of-session pulse
//   err_o            sticky field-range error, cleared by the next start
// -----------------------------------------------------------------------------
module sa_signal_word_packer #(
  parameter int N_ROWS_ARRAY     = 4,
  parameter int N                = 3,
  parameter int MAX_LEN_TRANSFER = 4,
  parameter int SEL_MUX_TR_WIDTH = $clog2(MAX_LEN_TRANSFER),
  parameter int SEL_WIDTH        = $clog2(N),
  parameter int NUM_COL_WIDTH    = $clog2(N + 1),
  parameter int ROM_SIG_WIDTH    = 100,
  parameter int SIG_ADDRS_WIDTH  = 10
) (
  input  logic                        clk_i,
  input  logic                        f_sel_rst,
  input  logic                        start_i,
  input  logic [SIG_ADDRS_WIDTH-1:0]  base_addrs_i,
  input  logic [SIG_ADDRS_WIDTH-1:0]  num_words_i,
  input  logic                        row_valid_i,
  output logic                        row_ready_o,
  input  logic [SEL_WIDTH-1:0]        row_f_sel_i,
  input  logic [NUM_COL_WIDTH-1:0]    row_num_cols_i,
  input  logic [SEL_MUX_TR_WIDTH-1:0] row_sel_mux_tr_i,
  input  logic                        row_en_adder_i,
  output logic                        wr_en_o,
  output logic [SIG_ADDRS_WIDTH-1:0]  wr_addrs_o,
  output logic [ROM_SIG_WIDTH-1:0]    wr_data_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o
);

  localparam int FIELDS_WIDTH  = N_ROWS_ARRAY * (SEL_WIDTH + NUM_COL_WIDTH + SEL_MUX_TR_WIDTH + 1);
  localparam int ROW_CNT_WIDTH = (N_ROWS_ARRAY > 1) ? $clog2(N_ROWS_ARRAY) : 1;
  localparam logic [ROW_CNT_WIDTH-1:0] LAST_ROW = ROW_CNT_WIDTH'(N_ROWS_ARRAY - 1);

  // Range limits carry one extra bit: N itself may not fit the field width.
  localparam logic [SEL_WIDTH:0]     F_SEL_LIMIT    = (SEL_WIDTH + 1)'(N);
  localparam logic [NUM_COL_WIDTH:0] NUM_COLS_LIMIT = (NUM_COL_WIDTH + 1)'(N);

  if (ROM_SIG_WIDTH < FIELDS_WIDTH) begin : g_width_check
    $error("ROM_SIG_WIDTH too small for the packed row fields");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [SIG_ADDRS_WIDTH-1:0] base_q, base_d;
  logic [SIG_ADDRS_WIDTH-1:0] num_words_q, num_words_d;
  logic [SIG_ADDRS_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [ROW_CNT_WIDTH-1:0]   row_cnt_q, row_cnt_d;

  // Row slots, one field set per array row.
  logic [N_ROWS_ARRAY-1:0][SEL_WIDTH-1:0]        f_sel_q, f_sel_d;
  logic [N_ROWS_ARRAY-1:0][NUM_COL_WIDTH-1:0]    num_cols_q, num_cols_d;
  logic [N_ROWS_ARRAY-1:0][SEL_MUX_TR_WIDTH-1:0] sel_mux_tr_q, sel_mux_tr_d;
  logic [N_ROWS_ARRAY-1:0]                       en_adder_q, en_adder_d;

  logic                       err_q, err_d;
  logic [SIG_ADDRS_WIDTH-1:0] wr_addrs_q, wr_addrs_d;
  logic [ROM_SIG_WIDTH-1:0]   wr_data_q, wr_data_d;

  logic start_acc;
  logic beat_acc;
  logic last_beat;
  logic last_word;
  logic bad_field;

  assign start_acc = (state_q == S_IDLE) && start_i;
  assign beat_acc  = (state_q == S_COLLECT) && row_valid_i;
  assign last_beat = beat_acc && (row_cnt_q == LAST_ROW);
  assign last_word = (word_cnt_q + SIG_ADDRS_WIDTH'(1)) == num_words_q;
  assign bad_field = (row_num_cols_i == '0)
                  || ({1'b0, row_num_cols_i} > NUM_COLS_LIMIT)
                  || ({1'b0, row_f_sel_i} >= F_SEL_LIMIT);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge f_sel_rst) begin
    if (f_sel_rst) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first, so no path leaves state_d unassigned
    // and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = (num_words_i == '0) ? S_DONE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (last_beat) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        state_d = last_word ? S_DONE : S_COLLECT;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs decoded from state only (no valid-to-ready path)
  // ---------------------------------------------------------------------------
  always_comb begin
    row_ready_o = 1'b0;
    wr_en_o     = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    unique case (state_q)
      S_IDLE:    busy_o      = 1'b0;
      S_COLLECT: row_ready_o = 1'b1;
      S_WRITE:   wr_en_o     = 1'b1;
      S_DONE:    done_o      = 1'b1;
      default:   busy_o      = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    base_d       = base_q;
    num_words_d  = num_words_q;
    word_cnt_d   = word_cnt_q;
    row_cnt_d    = row_cnt_q;
    f_sel_d      = f_sel_q;
    num_cols_d   = num_cols_q;
    sel_mux_tr_d = sel_mux_tr_q;
    en_adder_d   = en_adder_q;
    err_d        = err_q;
    wr_addrs_d   = wr_addrs_q;
    wr_data_d    = wr_data_q;

    if (start_acc) begin
      base_d      = base_addrs_i;
      num_words_d = num_words_i;
      word_cnt_d  = '0;
      row_cnt_d   = '0;
      err_d       = 1'b0;
    end

    if (beat_acc) begin
      // Out-of-range fields are flagged but stored exactly as received.
      f_sel_d[row_cnt_q]      = row_f_sel_i;
      num_cols_d[row_cnt_q]   = row_num_cols_i;
      sel_mux_tr_d[row_cnt_q] = row_sel_mux_tr_i;
      en_adder_d[row_cnt_q]   = row_en_adder_i;
      row_cnt_d               = last_beat ? '0 : row_cnt_q + ROW_CNT_WIDTH'(1);
      if (bad_field) begin
        err_d = 1'b1;
      end
    end

    // Load the write registers on the last beat so WRITE presents them
    // directly; the slot arrays already include this beat's fields.
    // Concatenating the packed slot arrays yields the layout documented above.
    if (last_beat) begin
      wr_addrs_d = base_q + word_cnt_q;
      wr_data_d  = ROM_SIG_WIDTH'({en_adder_d, sel_mux_tr_d, num_cols_d, f_sel_d});
    end

    if (state_q == S_WRITE) begin
      word_cnt_d = word_cnt_q + SIG_ADDRS_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge f_sel_rst) begin
    if (f_sel_rst) begin
      base_q       <= '0;
      num_words_q  <= '0;
      word_cnt_q   <= '0;
      row_cnt_q    <= '0;
      // NOTE: the row slots are a few flops wide, not a RAM, so resetting
      // them is cheap and guarantees no stale fields leak into a word.
      f_sel_q      <= '0;
      num_cols_q   <= '0;
      sel_mux_tr_q <= '0;
      en_adder_q   <= '0;
      err_q        <= 1'b0;
      wr_addrs_q   <= '0;
      wr_data_q    <= '0;
    end else begin
      base_q       <= base_d;
      num_words_q  <= num_words_d;
      word_cnt_q   <= word_cnt_d;
      row_cnt_q    <= row_cnt_d;
      f_sel_q      <= f_sel_d;
      num_cols_q   <= num_cols_d;
      sel_mux_tr_q <= sel_mux_tr_d;
      en_adder_q   <= en_adder_d;
      err_q        <= err_d;
      wr_addrs_q   <= wr_addrs_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign wr_addrs_o = wr_addrs_q;
  assign wr_data_o  = wr_data_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_sa_signal_word_packer.sv
// -----------------------------------------------------------------------------
// tb_sa_signal_word_packer
//
// Directed bench for sa_signal_word_packer with default parameters
// (4 rows, 2-bit fields, 100-bit word, 10-bit address). Inputs are driven
// 1 ns after the rising edge; a negedge monitor records every write and
// done pulse with its cycle number.
// -----------------------------------------------------------------------------
module tb_sa_signal_word_packer;

  localparam int AW = 10;
  localparam int DW = 100;

  logic          clk_i = 1'b0;
  logic          f_sel_rst;
  logic          start_i;
  logic [AW-1:0] base_addrs_i;
  logic [AW-1:0] num_words_i;
  logic          row_valid_i;
  logic          row_ready_o;
  logic [1:0]    row_f_sel_i;
  logic [1:0]    row_num_cols_i;
  logic [1:0]    row_sel_mux_tr_i;
  logic          row_en_adder_i;
  logic          wr_en_o;
  logic [AW-1:0] wr_addrs_o;
  logic [DW-1:0] wr_data_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  sa_signal_word_packer dut (
    .clk_i            (clk_i),
    .f_sel_rst        (f_sel_rst),
    .start_i          (start_i),
    .base_addrs_i     (base_addrs_i),
    .num_words_i      (num_words_i),
    .row_valid_i      (row_valid_i),
    .row_ready_o      (row_ready_o),
    .row_f_sel_i      (row_f_sel_i),
    .row_num_cols_i   (row_num_cols_i),
    .row_sel_mux_tr_i (row_sel_mux_tr_i),
    .row_en_adder_i   (row_en_adder_i),
    .wr_en_o          (wr_en_o),
    .wr_addrs_o       (wr_addrs_o),
    .wr_data_o        (wr_data_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .err_o            (err_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Write / done monitor.
  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  int            wc_q[$];
  int            dc_q[$];

  always @(negedge clk_i) begin
    if (wr_en_o) begin
      wa_q.push_back(wr_addrs_o);
      wd_q.push_back(wr_data_o);
      wc_q.push_back(cyc);
    end
    if (done_o) dc_q.push_back(cyc);
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Current word's rows, as (f_sel, num_cols, sel_mux_tr, en_adder).
  logic [1:0] t_fs  [4];
  logic [1:0] t_nc  [4];
  logic [1:0] t_smt [4];
  logic       t_en  [4];

  task automatic set_row(input int j, input logic [1:0] fs, input logic [1:0] nc,
                         input logic [1:0] smt, input logic en);
    t_fs[j]  = fs;
    t_nc[j]  = nc;
    t_smt[j] = smt;
    t_en[j]  = en;
  endtask

  task automatic rows_a();
    set_row(0, 2'd0, 2'd3, 2'd0, 1'b1);
    set_row(1, 2'd1, 2'd2, 2'd1, 1'b0);
    set_row(2, 2'd2, 2'd1, 2'd2, 1'b1);
    set_row(3, 2'd0, 2'd3, 2'd3, 1'b1);
  endtask

  // Reference packing with explicit field offsets for the default geometry.
  function automatic logic [DW-1:0] pack_model();
    logic [DW-1:0] w;
    w = '0;
    for (int j = 0; j < 4; j++) begin
      w[j*2 +: 2]      = t_fs[j];
      w[8 + j*2 +: 2]  = t_nc[j];
      w[16 + j*2 +: 2] = t_smt[j];
      w[24 + j]        = t_en[j];
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    dc_q.delete();
  endtask

  task automatic do_start(input logic [AW-1:0] base, input logic [AW-1:0] num);
    base_addrs_i = base;
    num_words_i  = num;
    start_i      = 1'b1;
    tick();
    start_i      = 1'b0;
  endtask

  // Presents row j and holds valid until the DUT accepts it (bounded).
  task automatic send_beat(input int j);
    bit taken;
    taken            = 1'b0;
    row_valid_i      = 1'b1;
    row_f_sel_i      = t_fs[j];
    row_num_cols_i   = t_nc[j];
    row_sel_mux_tr_i = t_smt[j];
    row_en_adder_i   = t_en[j];
    for (int k = 0; k < 20; k++) begin
      if (row_ready_o) begin
        tick();
        taken = 1'b1;
        break;
      end
      tick();
    end
    if (!taken) check("beat_accept_timeout", 128'(0), 128'(1));
  endtask

  task automatic send_rows(input int first, input int last);
    for (int j = first; j <= last; j++) send_beat(j);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 40; k++) begin
      if (!busy_o) break;
      tick();
    end
    check(tag, 128'(busy_o), 128'(0));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    f_sel_rst        = 1'b1;
    start_i          = 1'b0;
    base_addrs_i     = '0;
    num_words_i      = '0;
    row_valid_i      = 1'b0;
    row_f_sel_i      = '0;
    row_num_cols_i   = '0;
    row_sel_mux_tr_i = '0;
    row_en_adder_i   = 1'b0;

    // ---------------- reset values ----------------
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_ready",  128'(row_ready_o), 128'(0));
    check("rst_wr_en",  128'(wr_en_o),     128'(0));
    check("rst_busy",   128'(busy_o),      128'(0));
    check("rst_done",   128'(done_o),      128'(0));
    check("rst_err",    128'(err_o),       128'(0));
    check("rst_addr",   128'(wr_addrs_o),  128'(0));
    check("rst_data",   128'(wr_data_o),   128'(0));
    f_sel_rst = 1'b0;
    tick();

    // ---------------- single word, base 5 ----------------
    clear_log();
    rows_a();
    do_start(10'd5, 10'd1);
    check("single_ready_latency", 128'(row_ready_o), 128'(1));
    check("single_busy",          128'(busy_o),      128'(1));
    send_rows(0, 3);
    row_valid_i = 1'b0;
    check("single_wr_latency", 128'(wr_en_o), 128'(1));
    wait_idle("single_idle");
    check("single_nwrites", 128'(wa_q.size()), 128'(1));
    check("single_ndone",   128'(dc_q.size()), 128'(1));
    if (wa_q.size() == 1 && dc_q.size() == 1) begin
      check("single_addr",      128'(wa_q[0]),  128'(10'd5));
      check("single_data",      128'(wd_q[0]),  128'(32'h0DE4_DB24));
      check("single_done_lat",  128'(dc_q[0]),  128'(wc_q[0] + 1));
    end
    check("single_err", 128'(err_o), 128'(0));

    // ---------------- async reset mid-COLLECT ----------------
    clear_log();
    do_start(10'd9, 10'd1);
    send_rows(0, 1);
    row_valid_i = 1'b0;
    #3;
    f_sel_rst = 1'b1;
    #1;
    check("arst_busy",  128'(busy_o),      128'(0));
    check("arst_ready", 128'(row_ready_o), 128'(0));
    check("arst_wr_en", 128'(wr_en_o),     128'(0));
    check("arst_done",  128'(done_o),      128'(0));
    check("arst_addr",  128'(wr_addrs_o),  128'(0));
    check("arst_data",  128'(wr_data_o),   128'(0));
    #2;
    f_sel_rst = 1'b0;
    tick();
    check("arst_no_write", 128'(wa_q.size()), 128'(0));
    check("arst_no_done",  128'(dc_q.size()), 128'(0));
    set_row(0, 2'd1, 2'd1, 2'd3, 1'b0);
    set_row(1, 2'd2, 2'd3, 2'd0, 1'b1);
    set_row(2, 2'd0, 2'd2, 2'd1, 1'b0);
    set_row(3, 2'd1, 2'd1, 2'd2, 1'b1);
    do_start(10'd9, 10'd1);
    send_rows(0, 3);
    row_valid_i = 1'b0;
    wait_idle("arst_idle");
    check("arst_clean_nwrites", 128'(wa_q.size()), 128'(1));
    if (wa_q.size() == 1) begin
      check("arst_clean_addr", 128'(wa_q[0]), 128'(10'd9));
      check("arst_clean_data", 128'(wd_q[0]), 128'(pack_model()));
    end

    // ---------------- multi-word with address wrap ----------------
    clear_log();
    rows_a();
    do_start(10'd1022, 10'd3);
    send_rows(0, 3);
    send_rows(0, 3);
    send_rows(0, 3);
    row_valid_i = 1'b0;
    wait_idle("wrap_idle");
    check("wrap_nwrites", 128'(wa_q.size()), 128'(3));
    check("wrap_ndone",   128'(dc_q.size()), 128'(1));
    if (wa_q.size() == 3 && dc_q.size() == 1) begin
      check("wrap_addr0",    128'(wa_q[0]), 128'(10'd1022));
      check("wrap_addr1",    128'(wa_q[1]), 128'(10'd1023));
      check("wrap_addr2",    128'(wa_q[2]), 128'(10'd0));
      check("wrap_gap01",    128'(wc_q[1] - wc_q[0]), 128'(5));
      check("wrap_gap12",    128'(wc_q[2] - wc_q[1]), 128'(5));
      check("wrap_data2",    128'(wd_q[2]), 128'(32'h0DE4_DB24));
      check("wrap_done_lat", 128'(dc_q[0]), 128'(wc_q[2] + 1));
    end

    // ---------------- stall after the first beat ----------------
    clear_log();
    do_start(10'd20, 10'd1);
    send_rows(0, 0);
    row_valid_i = 1'b0;
    repeat (7) tick();
    check("stall_no_write", 128'(wa_q.size()), 128'(0));
    check("stall_ready",    128'(row_ready_o), 128'(1));
    send_rows(1, 3);
    row_valid_i = 1'b0;
    wait_idle("stall_idle");
    check("stall_nwrites", 128'(wa_q.size()), 128'(1));
    if (wa_q.size() == 1) begin
      check("stall_addr", 128'(wa_q[0]), 128'(10'd20));
      check("stall_data", 128'(wd_q[0]), 128'(32'h0DE4_DB24));
    end

    // ---------------- zero word count ----------------
    clear_log();
    do_start(10'd50, 10'd0);
    check("zero_done_lat", 128'(done_o), 128'(1));
    tick();
    check("zero_done_once", 128'(done_o), 128'(0));
    check("zero_idle",      128'(busy_o), 128'(0));
    tick();
    check("zero_no_write", 128'(wa_q.size()), 128'(0));
    check("zero_ndone",    128'(dc_q.size()), 128'(1));

    // ---------------- start ignored during COLLECT ----------------
    clear_log();
    do_start(10'd100, 10'd1);
    send_rows(0, 0);
    row_valid_i  = 1'b0;
    base_addrs_i = 10'd200;
    num_words_i  = 10'd5;
    start_i      = 1'b1;
    tick();
    start_i      = 1'b0;
    send_rows(1, 3);
    row_valid_i = 1'b0;
    wait_idle("ign_idle");
    check("ign_nwrites", 128'(wa_q.size()), 128'(1));
    check("ign_ndone",   128'(dc_q.size()), 128'(1));
    if (wa_q.size() == 1) check("ign_addr", 128'(wa_q[0]), 128'(10'd100));

    // ---------------- field-range error ----------------
    clear_log();
    set_row(0, 2'd1, 2'd0, 2'd1, 1'b1);
    set_row(1, 2'd3, 2'd2, 2'd0, 1'b0);
    set_row(2, 2'd0, 2'd1, 2'd2, 1'b1);
    set_row(3, 2'd2, 2'd3, 2'd3, 1'b0);
    do_start(10'd300, 10'd1);
    check("err_before", 128'(err_o), 128'(0));
    send_rows(0, 0);
    check("err_after_nc0", 128'(err_o), 128'(1));
    send_rows(1, 1);
    check("err_after_fsel3", 128'(err_o), 128'(1));
    send_rows(2, 3);
    row_valid_i = 1'b0;
    wait_idle("err_idle");
    check("err_sticky", 128'(err_o), 128'(1));
    check("err_nwrites", 128'(wa_q.size()), 128'(1));
    if (wa_q.size() == 1) check("err_raw_data", 128'(wd_q[0]), 128'(32'h05E1_D88D));
    do_start(10'd400, 10'd0);
    check("err_cleared_on_start", 128'(err_o), 128'(0));
    wait_idle("err_final_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sa_signal_word_packer.md
# sa_signal_word_packer

Assembles per-row systolic-array control fields into packed signal words and writes them, one word per array configuration, into the control-signal memory that the array controller fetches at run time. It sits between the host/configuration loader and the signal memory's write port. It is the writer end of the signal-word format, so its bit layout must match the controller's unpacking exactly.

## Interface
- N_ROWS_ARRAY, 4, rows per packed word (one field set per row)
- N, 3, maximum filter size
- MAX_LEN_TRANSFER, 4, transfer-mux depth
- SEL_MUX_TR_WIDTH, $clog2(MAX_LEN_TRANSFER), width of the sel_mux_tr field
- SEL_WIDTH, $clog2(N), width of the f_sel field
- NUM_COL_WIDTH, $clog2(N+1), width of the number_of_columns field
- ROM_SIG_WIDTH, 100, signal word width (must be ≥ N_ROWS_ARRAY*(SEL_WIDTH+NUM_COL_WIDTH+SEL_MUX_TR_WIDTH+1))
- SIG_ADDRS_WIDTH, 10, signal memory address width

Ports:
- clk_i  in  1  clock; all state on rising edge
- f_sel_rst  in  1  reset, asynchronous, active-high
- start_i  in  1  session start pulse; sampled only in IDLE
- base_addrs_i  in  SIG_ADDRS_WIDTH  first write address, captured on start
- num_words_i  in  SIG_ADDRS_WIDTH  words in session, captured on start
- row_valid_i  in  1  row field beat valid
- row_ready_o  out  1  packer accepts a beat
- row_f_sel_i  in  SEL_WIDTH  filter-select field
- row_num_cols_i  in  NUM_COL_WIDTH  column count field
- row_sel_mux_tr_i  in  SEL_MUX_TR_WIDTH  transfer-mux select field
- row_en_adder_i  in  1  adder-node enable field
- wr_en_o  out  1  memory write strobe
- wr_addrs_o  out  SIG_ADDRS_WIDTH  write address
- wr_data_o  out  ROM_SIG_WIDTH  packed word
- busy_o  out  1  session in progress (state ≠ IDLE)
- done_o  out  1  one-cycle end-of-session pulse
- err_o  out  1  sticky field-range error

## Operation
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE: on start_i, capture base_addrs_i and num_words_i, clear err_o, word counter and row counter, then go to COLLECT. If num_words_i = 0, go to DONE instead.
- COLLECT:
  - row_ready_o = 1.
  - Each beat with valid&ready stores its fields in row slot row_cnt, then increments row_cnt.
  - The beat with row_cnt = N_ROWS_ARRAY-1 resets row_cnt to 0 and moves to WRITE.
- Packing of row j:
  - f_sel at [j*SEL_WIDTH +: SEL_WIDTH]
  - num_cols at [N_ROWS_ARRAY*SEL_WIDTH + j*NUM_COL_WIDTH +: NUM_COL_WIDTH]
  - sel_mux_tr at [N_ROWS_ARRAY*(SEL_WIDTH+NUM_COL_WIDTH) + j*SEL_MUX_TR_WIDTH +: SEL_MUX_TR_WIDTH]
  - en_adder at bit N_ROWS_ARRAY*(SEL_WIDTH+NUM_COL_WIDTH+SEL_MUX_TR_WIDTH) + j
  - All remaining upper bits are 0.
- WRITE:
  - Drive wr_en_o = 1 for exactly one cycle, with wr_addrs_o = base + word_cnt (modulo 2^SIG_ADDRS_WIDTH, wraps silently) and wr_data_o = the packed word.
  - Increment word_cnt.
  - If word_cnt+1 = num_words, go to DONE; else go to COLLECT.
- DONE: done_o = 1 for one cycle, then IDLE.
- err_o is set on any accepted beat with row_num_cols_i = 0, row_num_cols_i > N, or row_f_sel_i ≥ N. The offending field is still written unmodified. err_o holds until the next accepted start_i.
- start_i outside IDLE is ignored. row_valid_i outside COLLECT is ignored (no beat consumed).

## Timing
- Reset values: state IDLE; row_ready_o, wr_en_o, busy_o, done_o, err_o = 0; wr_addrs_o = 0; wr_data_o = 0; all counters and row slots = 0.
- All outputs are registered or decoded from state only; no combinational path from row_valid_i to row_ready_o.
- Latency:
  - start to first row_ready_o: 1 cycle.
  - Last row beat to wr_en_o: 1 cycle.
  - Last write to done_o: 1 cycle.
- Throughput: with valid held high, a word takes N_ROWS_ARRAY+1 cycles (no ready during WRITE).
- wr_data_o and wr_addrs_o hold their last written values after the write; they are meaningful only when wr_en_o = 1.
- valid low mid-word stalls COLLECT with the partial word retained, with no timeout.
- f_sel_rst mid-session aborts immediately: the partial word is discarded, no write, no done_o.

## Test plan
- Reset: assert f_sel_rst asynchronously mid-COLLECT (2 of 4 beats taken) -> all outputs 0 within the same cycle, IDLE; a new start with 4 beats writes one clean word.
- Single word, defaults, base=5, count=1, rows (f_sel,num_cols,smt,en) = (0,3,0,1),(1,2,1,0),(2,1,2,1),(0,3,3,1) -> exactly one wr_en_o, wr_addrs_o=5, wr_data_o=0x0DE4DB24, done_o 1 cycle after the write.
- Multi-word wrap: base=1022, count=3, valid always high -> writes at 1022, 1023, 0, spaced 5 cycles apart; done_o once; busy_o low afterwards.
- Backpressure/stall: deassert valid for 7 cycles after beat 1 -> no write until 4 beats are accepted; the packed word equals the no-stall result.
- Zero count and ignored start: num_words_i=0 -> done_o 1 cycle after start, no wr_en_o; start_i pulsed during COLLECT -> no effect on address or count.
- Error flag: a beat with num_cols=0, then a beat with f_sel=3 -> err_o rises after the first of these, the word is still written with the raw fields, and err_o clears on the next start.
